mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the CPU's single 16-bit memory port between instruction fetch (requester 0)
//  and load/store (requester 1), one transaction at a time.
//  Round-robin arbitration with a req/gnt/done handshake.
//  Drives the select lines of the existing 16-bit 2:1 muxes that steer address and write data.
//  Includes a watchdog that aborts a transaction when memory never acknowledges.
// PARAMETERS
//  DATA_W    16  data width of rdata/wdata
//  ADDR_W    16  address width
//  MAX_WAIT  15  cycles in ACTIVE without mem_ack before abort (>=1); counter width $clog2(MAX_WAIT+1)
// PORTS
//  clk        in   1       single clock, all state on posedge
//  rst        in   1       synchronous, active-high reset
//  req0/req1  in   1       requester transaction request, level
//  addr0/1    in   ADDR_W  requester address, stable while req high until done
//  wdata0/1   in   DATA_W  requester write data
//  we0/we1    in   1       1 = write, 0 = read
//  gnt0/gnt1  out  1       registered grant, one-hot or zero
//  done0/1    out  1       one-cycle completion pulse to the granted requester
//  err0/err1  out  1       one-cycle pulse with done when the transaction timed out
//  rdata      out  DATA_W  read data captured on mem_ack, valid while done pulses
//  sel        out  1       mux select: 0 = requester 0, 1 = requester 1
//  mem_req    out  1       memory request, high for the whole ACTIVE state
//  mem_we     out  1       write enable of the granted requester (0 outside ACTIVE)
//  mem_addr   out  ADDR_W  steered address (sel-muxed)
//  mem_wdata  out  DATA_W  steered write data (sel-muxed)
//  mem_ack    in   1       memory completion, single-cycle
//  mem_rdata  in   DATA_W  read data, valid with mem_ack
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; gnt*, done*, err*, mem_req, mem_we = 0; sel = 0; rdata = 0
//   - last_gnt = 1, so requester 0 wins the first tie; wait counter = 0
//  FSM states: IDLE -> ACTIVE -> COMPLETE -> IDLE.
//  IDLE:
//   - Any req high: pick winner, register gnt/sel, go to ACTIVE in the next cycle.
//   - Both high: grant the index != last_gnt. One high: grant it.
//  ACTIVE:
//   - mem_req=1; counter increments each cycle.
//   - mem_ack=1: capture mem_rdata into rdata, go to COMPLETE.
//   - Counter reaches MAX_WAIT without ack: go to COMPLETE with err flagged.
//  COMPLETE (one cycle):
//   - done[gnt]=1 (and err[gnt] if timed out); mem_req=0.
//   - Update last_gnt; clear gnt and counter; go to IDLE.
//  Latency: req sampled at edge N -> gnt/mem_req high from N+1. Ack at edge M -> done high in cycle M+1.
//  Back-to-back: minimum 3 cycles per transaction; a new grant is possible in the cycle after COMPLETE.
//  Boundary conditions:
//   - req dropped mid-ACTIVE: ignored, the transaction completes normally.
//   - mem_ack in IDLE or COMPLETE: ignored.
//   - mem_ack in the same cycle the counter hits MAX_WAIT: ack wins, err=0.
//   - rst mid-transaction: immediate return to reset values, no done pulse.
//   - sel holds its last value in IDLE; mem_addr/mem_wdata are don't-care when mem_req=0.
//   - rdata holds until the next ack. On timeout rdata is not updated.
// STRUCTURE
//  mem_arb_pkg:
//   - typedef enum logic [1:0] {IDLE, ACTIVE, COMPLETE} arb_state_t
//   - localparams SEL_REQ0=1'b0, SEL_REQ1=1'b1
//  Sub-module rr_pick2: combinational req0, req1, last_gnt -> valid, winner index.
//  Steering: two existing mux_16bit_2to1 instances (addr and wdata), S=sel.
//  Widths other than 16 are not supported by these instances; ADDR_W/DATA_W stay 16 here.
// TESTING
//  1. Single read: req0, addr0=0x1234, ack after 2 cycles with rdata 0xBEEF
//     -> gnt0 one cycle after req, done0=1, rdata=0xBEEF, err0=0.
//  2. Tie after reset: req0 and req1 both high
//     -> 0 served first, then 1. Continued ties alternate 0,1,0,1 over 4 transactions.
//  3. Write steering: req1, we1=1, addr1=0x00F0, wdata1=0xA5A5
//     -> sel=1, mem_we=1, mem_addr=0x00F0, mem_wdata=0xA5A5 during ACTIVE.
//  4. Timeout: MAX_WAIT=15, req0 with no ack
//     -> mem_req high 15 cycles, then done0=err0=1, rdata unchanged.
//  5. Ack on the cycle the counter hits MAX_WAIT -> done0=1, err0=0, rdata captured.
//  6. rst pulse mid-ACTIVE
//     -> next cycle all outputs 0, no done. Subsequent tie grants requester 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    COMPLETE = 2'd2
  } arb_state_t;

  localparam logic SEL_REQ0 = 1'b0;
  localparam logic SEL_REQ1 = 1'b1;

  // Turns a requester index into its one-hot grant vector.
  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return (idx == SEL_REQ1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mux_16bit_2to1.sv
// Existing 16-bit 2:1 mux used to steer address and write data onto the memory port.
module mux_16bit_2to1 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        s,
  output logic [15:0] y
);

  // Select b when s is high, a otherwise.
  always_comb begin
    y = s ? b : a;
  end

endmodule

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that was not served last wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic valid,
  output logic winner
);

  // Any request makes the pick valid; ties alternate away from the last winner.
  always_comb begin
    valid  = req0 | req1;
    winner = 1'b0;
    if (req0 && req1) begin
      winner = ~last_gnt;
    end else if (req1) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch (0) and load/store (1),
// one transaction at a time, with a watchdog that aborts unacknowledged accesses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we0,
  input  logic              we1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata,
  output logic              sel,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int               CNT_W      = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  arb_state_t        state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next, cnt_inc;
  logic [1:0]        gnt, gnt_next;
  logic [1:0]        done, done_next;
  logic [1:0]        err, err_next;
  logic              sel_q, sel_next;
  logic              last_gnt, last_gnt_next;
  logic [DATA_W-1:0] rdata_q, rdata_next;
  logic              pick_valid;
  logic              pick_winner;

  rr_pick2 u_pick (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (last_gnt),
    .valid    (pick_valid),
    .winner   (pick_winner)
  );

  assign cnt_inc = cnt + CNT_W'(1);

  // State register and all registered outputs; last_gnt resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      gnt      <= '0;
      done     <= '0;
      err      <= '0;
      sel_q    <= SEL_REQ0;
      last_gnt <= SEL_REQ1;
      rdata_q  <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      gnt      <= gnt_next;
      done     <= done_next;
      err      <= err_next;
      sel_q    <= sel_next;
      last_gnt <= last_gnt_next;
      rdata_q  <= rdata_next;
    end
  end

  // Next-state logic: grant in IDLE, wait for ack or watchdog in ACTIVE, pulse done in COMPLETE.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    gnt_next      = gnt;
    done_next     = 2'b00;
    err_next      = 2'b00;
    sel_next      = sel_q;
    last_gnt_next = last_gnt;
    rdata_next    = rdata_q;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next = ACTIVE;
          gnt_next   = idx_to_onehot(pick_winner);
          sel_next   = pick_winner;
          cnt_next   = '0;
        end
      end
      ACTIVE: begin
        if (mem_ack) begin
          rdata_next = mem_rdata;
          done_next  = gnt;
          state_next = COMPLETE;
        end else if (cnt_inc == WAIT_LIMIT) begin
          done_next  = gnt;
          err_next   = gnt;
          state_next = COMPLETE;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      COMPLETE: begin
        state_next    = IDLE;
        gnt_next      = 2'b00;
        cnt_next      = '0;
        last_gnt_next = sel_q;
      end
      default: begin
        state_next = IDLE;
        gnt_next   = 2'b00;
        cnt_next   = '0;
      end
    endcase
  end

  assign gnt0    = gnt[0];
  assign gnt1    = gnt[1];
  assign done0   = done[0];
  assign done1   = done[1];
  assign err0    = err[0];
  assign err1    = err[1];
  assign rdata   = rdata_q;
  assign sel     = sel_q;
  assign mem_req = (state == ACTIVE);
  assign mem_we  = mem_req & ((sel_q == SEL_REQ1) ? we1 : we0);

  mux_16bit_2to1 u_addr_mux (
    .a (addr0),
    .b (addr1),
    .s (sel_q),
    .y (mem_addr)
  );

  mux_16bit_2to1 u_wdata_mux (
    .a (wdata0),
    .b (wdata1),
    .s (sel_q),
    .y (mem_wdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        we0, we1;
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [15:0] rdata;
  logic        sel, mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  int          checks = 0;
  int          errors = 0;
  int          lastServed;
  logic [15:0] expRdata;

  mem_port_arbiter #(.DATA_W(16), .ADDR_W(16), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .we0(we0), .we1(we1),
    .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1),
    .err0(err0), .err1(err1),
    .rdata(rdata), .sel(sel),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value differs from the expected one.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // All control outputs must read back as their reset values.
  task automatic checkResetState(input string tag);
    checkOutput({tag, "_gnt"},  32'({gnt1, gnt0}), 32'd0);
    checkOutput({tag, "_done"}, 32'({done1, done0}), 32'd0);
    checkOutput({tag, "_err"},  32'({err1, err0}), 32'd0);
    checkOutput({tag, "_req"},  32'(mem_req), 32'd0);
    checkOutput({tag, "_we"},   32'(mem_we), 32'd0);
    checkOutput({tag, "_sel"},  32'(sel), 32'd0);
    checkOutput({tag, "_rdata"}, 32'(rdata), 32'd0);
  endtask

  // Run one transaction from an IDLE cycle: ackDelay is the ACTIVE cycle index that sees
  // mem_ack (>= MAX_WAIT means never), resetAt the ACTIVE cycle index that sees rst (-1 = none).
  task automatic applyStimulus(input logic r0, input logic r1,
                               input logic [15:0] a0, input logic [15:0] a1,
                               input logic [15:0] d0, input logic [15:0] d1,
                               input logic w0, input logic w1,
                               input int ackDelay, input logic [15:0] ackData,
                               input int resetAt);
    int          winner;
    logic [1:0]  oneHot;
    int          reqCycles;
    bit          timedOut;
    req0 = r0; req1 = r1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1; we0 = w0; we1 = w1;
    mem_ack   = ($urandom_range(0, 3) == 0);
    mem_rdata = 16'($urandom);
    if (r0 && r1) winner = 1 - lastServed;
    else          winner = r1 ? 1 : 0;
    oneHot = (winner == 1) ? 2'b10 : 2'b01;
    tick;
    req0 = 1'b0; req1 = 1'b0; mem_ack = 1'b0;
    checkOutput("gnt",       32'({gnt1, gnt0}), 32'(oneHot));
    checkOutput("sel",       32'(sel), 32'(winner));
    checkOutput("mem_we",    32'(mem_we), 32'((winner == 1) ? w1 : w0));
    checkOutput("mem_addr",  32'(mem_addr), 32'((winner == 1) ? a1 : a0));
    checkOutput("mem_wdata", 32'(mem_wdata), 32'((winner == 1) ? d1 : d0));
    reqCycles = 0;
    timedOut  = 1'b1;
    for (int k = 0; k < MAX_WAIT; k++) begin
      if (mem_req) reqCycles++;
      if (k == resetAt) begin
        rst = 1'b1;
        tick;
        rst = 1'b0;
        lastServed = 1;
        expRdata   = 16'h0000;
        checkResetState("mid_reset");
        return;
      end
      if (k == ackDelay) begin
        mem_ack   = 1'b1;
        mem_rdata = ackData;
      end
      tick;
      mem_ack = 1'b0;
      if (k == ackDelay) begin
        timedOut = 1'b0;
        break;
      end
    end
    checkOutput("mem_req_cycles", 32'(reqCycles), timedOut ? 32'(MAX_WAIT) : 32'(ackDelay + 1));
    if (!timedOut) expRdata = ackData;
    checkOutput("done",          32'({done1, done0}), 32'(oneHot));
    checkOutput("err",           32'({err1, err0}), timedOut ? 32'(oneHot) : 32'd0);
    checkOutput("rdata",         32'(rdata), 32'(expRdata));
    checkOutput("complete_req",  32'(mem_req), 32'd0);
    lastServed = winner;
    mem_ack   = ($urandom_range(0, 1) == 1);
    mem_rdata = 16'($urandom);
    tick;
    mem_ack = 1'b0;
    checkOutput("idle_gnt",   32'({gnt1, gnt0}), 32'd0);
    checkOutput("idle_done",  32'({done1, done0}), 32'd0);
    checkOutput("idle_req",   32'(mem_req), 32'd0);
    checkOutput("idle_rdata", 32'(rdata), 32'(expRdata));
  endtask

  // Directed scenarios first, then randomized transactions.
  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    lastServed = 1;
    expRdata   = 16'h0000;
    tick;
    tick;
    rst = 1'b0;
    checkResetState("reset");

    for (int t = 0; t < 4; t++) begin
      applyStimulus(1'b1, 1'b1, 16'h1000, 16'h2000, 16'h0, 16'h0, 1'b0, 1'b0,
                    t % 3, 16'(16'h0100 + t), -1);
    end
    applyStimulus(1'b1, 1'b0, 16'h1234, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1, 16'hBEEF, -1);
    applyStimulus(1'b0, 1'b1, 16'h0, 16'h00F0, 16'h0, 16'hA5A5, 1'b0, 1'b1, 2, 16'h5555, -1);
    applyStimulus(1'b1, 1'b0, 16'h0042, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 100, 16'hDEAD, -1);
    applyStimulus(1'b1, 1'b0, 16'h0043, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, MAX_WAIT - 1, 16'hC0DE, -1);
    applyStimulus(1'b1, 1'b1, 16'h0044, 16'h0045, 16'h0, 16'h0, 1'b0, 1'b1, 100, 16'hFFFF, 3);
    applyStimulus(1'b1, 1'b1, 16'h0046, 16'h0047, 16'h0, 16'h0, 1'b0, 1'b0, 0, 16'h1357, -1);

    for (int t = 0; t < 60; t++) begin
      logic r0, r1;
      int   rstAt;
      r0 = ($urandom_range(0, 1) == 1);
      r1 = ($urandom_range(0, 1) == 1);
      if (!r0 && !r1) begin
        r0 = 1'b1;
        r1 = 1'b1;
      end
      rstAt = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : -1;
      applyStimulus(r0, r1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                    int'($urandom_range(0, MAX_WAIT + 2)), 16'($urandom), rstAt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
